// File: rtl/mult_pkg.sv
// Shared types for the sequential shift-and-add multiplier.
package mult_pkg;

  // Controller states: waiting, iterating, presenting the product
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mult_state_e;

endpackage

// File: rtl/shift_add_multiplier_adder.sv
// N-bit ripple-carry adder used for the per-iteration partial-product sum.
module nbits_ripple_adder #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] carry;

  assign carry[0] = cin;

  // One full adder per bit, carry rippling from LSB to MSB
  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[N];

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential N x N unsigned shift-and-add multiplier, one iteration per clock.
// Optional build macro SHIFT_ADD_MULT_ZERO_BYPASS_EN: when defined, a start
// with a zero operand jumps straight to DONE with p=0 instead of iterating.
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] p
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  mult_state_e    state_q, state_d;
  logic [N-1:0]   mcand_q, mcand_d;
  logic [N-1:0]   acc_hi_q, acc_hi_d;
  logic [N-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] p_q, p_d;

  logic [N-1:0]   addend;
  logic [N-1:0]   sum;
  logic           cout;
  logic           zero_op;

  // Multiplicand is added only when the current multiplier LSB is set
  assign addend = mplier_q[0] ? mcand_q : '0;

  nbits_ripple_adder #(.N(N)) u_adder (
    .a    (acc_hi_q),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

`ifdef SHIFT_ADD_MULT_ZERO_BYPASS_EN
  assign zero_op = (a == '0) || (b == '0);
`else
  assign zero_op = 1'b0;
`endif

  // Next-state logic: operand load, shift-add iteration, product capture
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_hi_d = acc_hi_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mcand_d  = a;
          mplier_d = b;
          acc_hi_d = '0;
          cnt_d    = '0;
          if (zero_op) begin
            state_d = DONE;
            p_d     = '0;
          end else begin
            state_d = BUSY;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        // Carry-out becomes the new MSB so the 2N-bit product stays exact
        acc_hi_d = {cout, sum[N-1:1]};
        mplier_d = {sum[0], mplier_q[N-1:1]};
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          p_d     = {cout, sum, mplier_q[N-1:1]};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      acc_hi_q <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      p_q      <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_hi_q <= acc_hi_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
    end
  end

  assign busy = (state_q == BUSY);
  assign done = (state_q == DONE);
  assign p    = p_q;

endmodule
